// File: rtl/cpu_accel_port.sv
// CPU-side responder for the accelerator port: per-channel TX/RX FIFOs with valid/ready streams.
// Optional `ACCEL_PORT_LOOPBACK_EN adds a `loopback` input that routes each TX head into its own RX FIFO.
module cpu_accel_port #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef ACCEL_PORT_LOOPBACK_EN
    input  logic                               loopback,
`endif
    input  logic [ID_WIDTH-1:0]                accel_id,
    output logic                               accel_can_read,
    output logic                               accel_can_write,
    input  logic                               accel_read_enable,
    output logic [DATA_WIDTH-1:0]              accel_read_data,
    input  logic                               accel_write_enable,
    input  logic [DATA_WIDTH-1:0]              accel_write_data,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    input  logic [NUM_CHANNELS-1:0]            out_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    output logic [NUM_CHANNELS-1:0]            in_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                               proto_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0]         ptr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    word_t tx_mem_q [NUM_CHANNELS][FIFO_DEPTH];
    word_t tx_mem_d [NUM_CHANNELS][FIFO_DEPTH];
    word_t rx_mem_q [NUM_CHANNELS][FIFO_DEPTH];
    word_t rx_mem_d [NUM_CHANNELS][FIFO_DEPTH];
    ptr_t  tx_wr_q [NUM_CHANNELS], tx_wr_d [NUM_CHANNELS];
    ptr_t  tx_rd_q [NUM_CHANNELS], tx_rd_d [NUM_CHANNELS];
    ptr_t  tx_cnt_q[NUM_CHANNELS], tx_cnt_d[NUM_CHANNELS];
    ptr_t  rx_wr_q [NUM_CHANNELS], rx_wr_d [NUM_CHANNELS];
    ptr_t  rx_rd_q [NUM_CHANNELS], rx_rd_d [NUM_CHANNELS];
    ptr_t  rx_cnt_q[NUM_CHANNELS], rx_cnt_d[NUM_CHANNELS];
    logic  proto_err_q, proto_err_d;

    logic [NUM_CHANNELS-1:0] sel, tx_empty, tx_full, rx_empty, rx_full;
    logic [NUM_CHANNELS-1:0] tx_push, tx_pop, rx_push, rx_pop;
    word_t tx_head [NUM_CHANNELS];
    word_t rx_head [NUM_CHANNELS];
    word_t rx_word [NUM_CHANNELS];
    logic  id_valid;
    logic  lb_active;

`ifdef ACCEL_PORT_LOOPBACK_EN
    assign lb_active = loopback;
`else
    assign lb_active = 1'b0;
`endif

    always_comb begin
        sel             = '0;
        tx_empty        = '0;
        tx_full         = '0;
        rx_empty        = '0;
        rx_full         = '0;
        out_valid       = '0;
        in_ready        = '0;
        out_data        = '0;
        accel_read_data = '0;
        accel_can_read  = 1'b0;
        accel_can_write = 1'b0;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            sel[ch]      = (accel_id == ID_WIDTH'(ch));
            tx_empty[ch] = (tx_cnt_q[ch] == '0);
            tx_full[ch]  = (tx_cnt_q[ch] == ptr_t'(FIFO_DEPTH));
            rx_empty[ch] = (rx_cnt_q[ch] == '0);
            rx_full[ch]  = (rx_cnt_q[ch] == ptr_t'(FIFO_DEPTH));
            tx_head[ch]  = tx_empty[ch] ? '0 : tx_mem_q[ch][tx_rd_q[ch][AW-1:0]];
            rx_head[ch]  = rx_empty[ch] ? '0 : rx_mem_q[ch][rx_rd_q[ch][AW-1:0]];
            // Stream handshakes are held off during reset and while looping back.
            out_valid[ch] = !tx_empty[ch] && !lb_active && !rst;
            in_ready[ch]  = !rx_full[ch] && !lb_active && !rst;
            out_data[ch*DATA_WIDTH +: DATA_WIDTH] = tx_head[ch];
            if (sel[ch]) begin
                accel_can_read  = !rx_empty[ch];
                accel_can_write = !tx_full[ch];
                accel_read_data = rx_head[ch];
            end
        end
        id_valid = |sel;
    end

    always_comb begin
        tx_push = '0;
        tx_pop  = '0;
        rx_push = '0;
        rx_pop  = '0;
        proto_err_d = proto_err_q;
        if ((accel_read_enable || accel_write_enable) && !id_valid) begin
            proto_err_d = 1'b1;
        end
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            tx_push[ch] = sel[ch] && accel_write_enable && !tx_full[ch];
            rx_pop[ch]  = sel[ch] && accel_read_enable && !rx_empty[ch];
            if ((sel[ch] && accel_write_enable && tx_full[ch]) ||
                (sel[ch] && accel_read_enable && rx_empty[ch])) begin
                proto_err_d = 1'b1;
            end
            if (lb_active) begin
                tx_pop[ch]  = !tx_empty[ch] && !rx_full[ch];
                rx_push[ch] = tx_pop[ch];
                rx_word[ch] = tx_head[ch];
            end else begin
                tx_pop[ch]  = out_valid[ch] && out_ready[ch];
                rx_push[ch] = in_valid[ch] && in_ready[ch];
                rx_word[ch] = in_data[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            tx_wr_d[ch]  = tx_wr_q[ch];
            tx_rd_d[ch]  = tx_rd_q[ch];
            tx_cnt_d[ch] = tx_cnt_q[ch];
            rx_wr_d[ch]  = rx_wr_q[ch];
            rx_rd_d[ch]  = rx_rd_q[ch];
            rx_cnt_d[ch] = rx_cnt_q[ch];
            if (tx_push[ch]) begin
                tx_mem_d[ch][tx_wr_q[ch][AW-1:0]] = accel_write_data;
                tx_wr_d[ch] = ptr_inc(tx_wr_q[ch]);
            end
            if (tx_pop[ch]) begin
                tx_rd_d[ch] = ptr_inc(tx_rd_q[ch]);
            end
            if (tx_push[ch] && !tx_pop[ch]) begin
                tx_cnt_d[ch] = tx_cnt_q[ch] + ptr_t'(1);
            end else if (!tx_push[ch] && tx_pop[ch]) begin
                tx_cnt_d[ch] = tx_cnt_q[ch] - ptr_t'(1);
            end
            if (rx_push[ch]) begin
                rx_mem_d[ch][rx_wr_q[ch][AW-1:0]] = rx_word[ch];
                rx_wr_d[ch] = ptr_inc(rx_wr_q[ch]);
            end
            if (rx_pop[ch]) begin
                rx_rd_d[ch] = ptr_inc(rx_rd_q[ch]);
            end
            if (rx_push[ch] && !rx_pop[ch]) begin
                rx_cnt_d[ch] = rx_cnt_q[ch] + ptr_t'(1);
            end else if (!rx_push[ch] && rx_pop[ch]) begin
                rx_cnt_d[ch] = rx_cnt_q[ch] - ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
        if (rst) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                tx_wr_q[ch]  <= '0;
                tx_rd_q[ch]  <= '0;
                tx_cnt_q[ch] <= '0;
                rx_wr_q[ch]  <= '0;
                rx_rd_q[ch]  <= '0;
                rx_cnt_q[ch] <= '0;
            end
            proto_err_q <= 1'b0;
        end else begin
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cpu_accel_port.sv
// Scoreboard bench for cpu_accel_port: expected stream words are queued at stimulus time and
// popped by a monitor whenever a TX handshake or CPU read is about to occur.
module tb_cpu_accel_port;

    localparam int DW  = 16;
    localparam int IW  = 4;
    localparam int NCH = 2;
    localparam int DEP = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
`ifdef ACCEL_PORT_LOOPBACK_EN
    logic               loopback = 1'b0;
`endif
    logic [IW-1:0]      accel_id = '0;
    logic               accel_can_read, accel_can_write;
    logic               accel_read_enable = 1'b0;
    logic [DW-1:0]      accel_read_data;
    logic               accel_write_enable = 1'b0;
    logic [DW-1:0]      accel_write_data = '0;
    logic [NCH-1:0]     out_valid;
    logic [NCH-1:0]     out_ready = '0;
    logic [NCH*DW-1:0]  out_data;
    logic [NCH-1:0]     in_valid = '0;
    logic [NCH-1:0]     in_ready;
    logic [NCH*DW-1:0]  in_data = '0;
    logic               proto_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_tx[NCH][$];
    logic [DW-1:0] exp_rx[NCH][$];

    cpu_accel_port #(
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (IW),
        .NUM_CHANNELS(NCH),
        .FIFO_DEPTH  (DEP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef ACCEL_PORT_LOOPBACK_EN
        .loopback          (loopback),
`endif
        .accel_id          (accel_id),
        .accel_can_read    (accel_can_read),
        .accel_can_write   (accel_can_write),
        .accel_read_enable (accel_read_enable),
        .accel_read_data   (accel_read_data),
        .accel_write_enable(accel_write_enable),
        .accel_write_data  (accel_write_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(int id, logic [DW-1:0] d);
        accel_id           = IW'(id);
        accel_write_data   = d;
        accel_write_enable = 1'b1;
        tick();
        accel_write_enable = 1'b0;
    endtask

    task automatic drain_tx(int c);
        out_ready[c] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid[c]) break;
            tick();
        end
        chk("tx_drained", 32'(out_valid[c]), 32'd0);
        out_ready[c] = 1'b0;
    endtask

    task automatic drain_rx(int c);
        accel_id = IW'(c);
        for (int i = 0; i < 20; i++) begin
            if (!accel_can_read) break;
            accel_read_enable = 1'b1;
            tick();
        end
        accel_read_enable = 1'b0;
        chk("rx_drained", 32'(accel_can_read), 32'd0);
    endtask

    // Monitor: inputs only change just after posedge, so the negedge sees what the next edge commits.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (exp_tx[c].size() == 0) begin
                        chk("tx_unexpected", 32'(out_data[c*DW +: DW]), 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_word", 32'(out_data[c*DW +: DW]), 32'(exp_tx[c].pop_front()));
                    end
                end
            end
            if (accel_read_enable && accel_can_read) begin
                if (int'(accel_id) >= NCH || exp_rx[int'(accel_id)].size() == 0) begin
                    chk("rx_unexpected", 32'(accel_read_data), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_word", 32'(accel_read_data), 32'(exp_rx[int'(accel_id)].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        in_valid = '1;
        out_ready = '1;
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = '0;
        out_ready = '0;
        accel_id = '0;
        #1;
        chk("post_rst_can_read", 32'(accel_can_read), 32'd0);
        chk("post_rst_can_write", 32'(accel_can_write), 32'd1);
        chk("post_rst_read_data", 32'(accel_read_data), 32'd0);
        chk("post_rst_proto_err", 32'(proto_err), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'b11);

        // CPU -> accelerator on channel 0 with one-cycle latency
        exp_tx[0].push_back(16'h1234);
        cpu_write(0, 16'h1234);
        chk("tx_latency_valid", 32'(out_valid[0]), 32'd1);
        chk("tx_latency_data", 32'(out_data[0 +: DW]), 32'h1234);
        exp_tx[0].push_back(16'h5678);
        cpu_write(0, 16'h5678);
        drain_tx(0);

        // Accelerator -> CPU on channel 1
        in_data[1*DW +: DW] = 16'd42;
        in_valid[1] = 1'b1;
        exp_rx[1].push_back(16'd42);
        tick();
        in_valid[1] = 1'b0;
        accel_id = 4'd1;
        #1;
        chk("rx1_can_read", 32'(accel_can_read), 32'd1);
        chk("rx1_read_data", 32'(accel_read_data), 32'd42);
        accel_read_enable = 1'b1;
        tick();
        accel_read_enable = 1'b0;
        chk("rx1_can_read_after", 32'(accel_can_read), 32'd0);
        chk("rx1_proto_err", 32'(proto_err), 32'd0);

        // TX0 fill, overflow drop, ordered drain
        for (int i = 0; i < DEP; i++) begin
            exp_tx[0].push_back(16'hA000 + 16'(i));
            cpu_write(0, 16'hA000 + 16'(i));
        end
        chk("tx_full_can_write", 32'(accel_can_write), 32'd0);
        chk("tx_full_err_before", 32'(proto_err), 32'd0);
        cpu_write(0, 16'hDEAD);
        chk("tx_overflow_err", 32'(proto_err), 32'd1);
        drain_tx(0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_clears_err", 32'(proto_err), 32'd0);

        // RX0 full: a CPU read frees a slot only from the next cycle
        in_valid[0] = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            in_data[0 +: DW] = 16'hB000 + 16'(i);
            exp_rx[0].push_back(16'hB000 + 16'(i));
            tick();
        end
        in_data[0 +: DW] = 16'hBEEF;
        chk("rx_full_in_ready", 32'(in_ready[0]), 32'd0);
        accel_id = 4'd0;
        accel_read_enable = 1'b1;
        tick();
        accel_read_enable = 1'b0;
        chk("rx_count7_in_ready", 32'(in_ready[0]), 32'd1);
        exp_rx[0].push_back(16'hBEEF);
        tick();
        in_valid[0] = 1'b0;
        chk("rx_refull_in_ready", 32'(in_ready[0]), 32'd0);
        drain_rx(0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;

        // Out-of-range id
        accel_id = 4'd5;
        #1;
        chk("bad_id_can_read", 32'(accel_can_read), 32'd0);
        chk("bad_id_can_write", 32'(accel_can_write), 32'd0);
        cpu_write(5, 16'h5555);
        chk("bad_id_err", 32'(proto_err), 32'd1);
        chk("bad_id_no_write", 32'(out_valid), 32'd0);

        // Reset mid-burst discards everything
        for (int i = 0; i < 3; i++) begin
            exp_tx[0].push_back(16'hC000 + 16'(i));
            cpu_write(0, 16'hC000 + 16'(i));
        end
        in_data[1*DW +: DW] = 16'h7777;
        in_valid[1] = 1'b1;
        exp_rx[1].push_back(16'h7777);
        tick();
        in_valid[1] = 1'b1;
        rst = 1'b1;
        out_ready[0] = 1'b1;
        exp_tx[0].delete();
        exp_rx[1].delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = '0;
        out_ready = '0;
        accel_id = 4'd1;
        #1;
        chk("mid_rst_ch1_can_read", 32'(accel_can_read), 32'd0);
        accel_id = 4'd0;
        #1;
        chk("mid_rst_ch0_can_write", 32'(accel_can_write), 32'd1);
        chk("mid_rst_tx_empty", 32'(out_valid), 32'd0);
        chk("mid_rst_err", 32'(proto_err), 32'd0);

`ifdef ACCEL_PORT_LOOPBACK_EN
        loopback = 1'b1;
        out_ready = '1;
        for (int i = 1; i <= 3; i++) begin
            exp_rx[0].push_back(16'(i));
            cpu_write(0, 16'(i));
            chk("lb_out_valid", 32'(out_valid), 32'd0);
            chk("lb_in_ready", 32'(in_ready), 32'd0);
        end
        tick();
        tick();
        chk("lb_out_valid_end", 32'(out_valid), 32'd0);
        drain_rx(0);
        out_ready = '0;
        loopback = 1'b0;
`endif

        tick();
        for (int c = 0; c < NCH; c++) begin
            chk("tx_queue_left", 32'(exp_tx[c].size()), 32'd0);
            chk("rx_queue_left", 32'(exp_rx[c].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
